// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bus bundle.
// Groups the FU result handshake (fu_valid/fu_ready plus per-FU payload) and
// the registered CDB broadcast lanes (cdb_valid plus per-lane payload, with the
// shared cdb_ready back-pressure).
//   master : the arbiter (accepts FU results, drives CDB lanes)
//   slave  : the environment (FUs and CDB consumers)
interface cdb_arbiter_if #(
  parameter int NUM_FU         = 4,
  parameter int NUM_CDB        = 2,
  parameter int REG_VAL_WIDTH  = 32,
  parameter int PHYS_REG_WIDTH = 7,
  parameter int ROB_TAG_WIDTH  = 5
);
  logic [NUM_FU-1:0]                      fu_valid;
  logic [NUM_FU-1:0]                      fu_ready;
  logic [NUM_FU-1:0][PHYS_REG_WIDTH-1:0]  fu_dst_reg_addr;
  logic [NUM_FU-1:0][REG_VAL_WIDTH-1:0]   fu_result_val;
  logic [NUM_FU-1:0][ROB_TAG_WIDTH-1:0]   fu_inst_tag;

  logic                                   cdb_ready;
  logic [NUM_CDB-1:0]                     cdb_valid;
  logic [NUM_CDB-1:0][PHYS_REG_WIDTH-1:0] cdb_register_addr;
  logic [NUM_CDB-1:0][REG_VAL_WIDTH-1:0]  cdb_register_val;
  logic [NUM_CDB-1:0][ROB_TAG_WIDTH-1:0]  cdb_inst_tag;

  modport master (
    input  fu_valid, fu_dst_reg_addr, fu_result_val, fu_inst_tag, cdb_ready,
    output fu_ready, cdb_valid, cdb_register_addr, cdb_register_val, cdb_inst_tag
  );

  modport slave (
    output fu_valid, fu_dst_reg_addr, fu_result_val, fu_inst_tag, cdb_ready,
    input  fu_ready, cdb_valid, cdb_register_addr, cdb_register_val, cdb_inst_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter.
// Buffers each FU's results in a private FIFO, then every advancing cycle
// grants up to NUM_CDB non-empty FIFO heads in round-robin order (starting at
// rr_ptr) and broadcasts them on registered CDB lanes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : cdb_arbiter_if.master (FU handshake in, CDB lanes out)

// Per-FU result FIFO. count/pointers only; storage is not reset.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         not_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign not_full  = (count < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && !not_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && !not_empty));
endmodule

module cdb_arbiter #(
  parameter int NUM_FU         = 4,
  parameter int NUM_CDB        = 2,
  parameter int FIFO_DEPTH     = 2,
  parameter int REG_VAL_WIDTH  = 32,
  parameter int PHYS_REG_WIDTH = 7,
  parameter int ROB_TAG_WIDTH  = 5
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.master bus
);
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PHYS_REG_WIDTH-1:0] addr;
    logic [REG_VAL_WIDTH-1:0]  val;
    logic [ROB_TAG_WIDTH-1:0]  tag;
  } res_t;

  res_t [NUM_FU-1:0]  fu_res, head;
  logic [NUM_FU-1:0]  push, pop, grant, not_empty, not_full;
  res_t [NUM_CDB-1:0] lane_res;
  logic [NUM_CDB-1:0] lane_vld;
  logic [FW-1:0]      rr_ptr, rr_nxt;
  logic               adv;

  // Lanes only move when consumers accept or nothing is on the bus.
  assign adv = bus.cdb_ready | ~|bus.cdb_valid;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_res[i]       = {bus.fu_dst_reg_addr[i], bus.fu_result_val[i], bus.fu_inst_tag[i]};
    // Held low during reset so no FU hands off a result that would be dropped.
    assign bus.fu_ready[i] = reset & not_full[i];
    assign push[i]         = bus.fu_valid[i] & bus.fu_ready[i];
    assign pop[i]          = grant[i] & adv;

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(res_t))) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .din       (fu_res[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .not_empty (not_empty[i]),
      .not_full  (not_full[i])
    );
  end

  // Round-robin scan from rr_ptr; the k-th non-empty FIFO found feeds lane k.
  // Loops compare against loop constants so every index is static after unroll.
  always_comb begin
    int ng;
    int idx;
    grant    = '0;
    lane_vld = '0;
    lane_res = '0;
    rr_nxt   = rr_ptr;
    ng       = 0;
    idx      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
        if (i == idx && not_empty[i] && ng < NUM_CDB) begin
          for (int k = 0; k < NUM_CDB; k++) begin
            if (k == ng) begin
              lane_vld[k] = 1'b1;
              lane_res[k] = head[i];
            end
          end
          grant[i] = 1'b1;
          rr_nxt   = FW'((i + 1) % NUM_FU);
          ng       = ng + 1;
        end
      end
    end
  end

  // Ungranted lanes drop valid but keep their last payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr                <= '0;
      bus.cdb_valid         <= '0;
      bus.cdb_register_addr <= '0;
      bus.cdb_register_val  <= '0;
      bus.cdb_inst_tag      <= '0;
    end else if (adv) begin
      rr_ptr        <= rr_nxt;
      bus.cdb_valid <= lane_vld;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (lane_vld[k]) begin
          bus.cdb_register_addr[k] <= lane_res[k].addr;
          bus.cdb_register_val[k]  <= lane_res[k].val;
          bus.cdb_inst_tag[k]      <= lane_res[k].tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4, NUM_CDB=2, FIFO_DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_cdb_arbiter;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if #(.NUM_FU(4), .NUM_CDB(2), .REG_VAL_WIDTH(32),
                   .PHYS_REG_WIDTH(7), .ROB_TAG_WIDTH(5)) bus ();

  cdb_arbiter #(.NUM_FU(4), .NUM_CDB(2), .FIFO_DEPTH(2), .REG_VAL_WIDTH(32),
                .PHYS_REG_WIDTH(7), .ROB_TAG_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fu(input int i, input logic [6:0] a, input logic [31:0] v, input logic [4:0] t);
    bus.fu_valid[i]        = 1'b1;
    bus.fu_dst_reg_addr[i] = a;
    bus.fu_result_val[i]   = v;
    bus.fu_inst_tag[i]     = t;
  endtask

  task automatic lane(input string tag, input int k, input logic [6:0] a,
                      input logic [31:0] v, input logic [4:0] t);
    chk({tag, "_addr"}, bus.cdb_register_addr[k], a);
    chk({tag, "_val"},  bus.cdb_register_val[k],  v);
    chk({tag, "_tag"},  bus.cdb_inst_tag[k],      t);
  endtask

  initial begin
    reset = 1'b0;
    bus.fu_valid = '0;
    bus.fu_dst_reg_addr = '0;
    bus.fu_result_val = '0;
    bus.fu_inst_tag = '0;
    bus.cdb_ready = 1'b1;
    #1;
    chk("rst_ready_low", bus.fu_ready, 4'b0000);
    chk("rst_valid", bus.cdb_valid, 2'b00);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ready", bus.fu_ready, 4'b1111);
    chk("post_rst_addr", bus.cdb_register_addr, 14'd0);
    chk("post_rst_val", bus.cdb_register_val, 64'd0);
    chk("post_rst_tag", bus.cdb_inst_tag, 10'd0);
    tick();

    // Contention: all four FUs at once, rr_ptr=0.
    for (int i = 0; i < 4; i++) set_fu(i, 7'(20 + i), 32'hA0 + 32'(i), 5'(10 + i));
    tick();
    chk("rr_accept_no_bcast", bus.cdb_valid, 2'b00);
    bus.fu_valid = '0;
    tick();
    chk("rr_b1_valid", bus.cdb_valid, 2'b11);
    lane("rr_b1_l0", 0, 7'd20, 32'hA0, 5'd10);
    lane("rr_b1_l1", 1, 7'd21, 32'hA1, 5'd11);
    tick();
    chk("rr_b2_valid", bus.cdb_valid, 2'b11);
    lane("rr_b2_l0", 0, 7'd22, 32'hA2, 5'd12);
    lane("rr_b2_l1", 1, 7'd23, 32'hA3, 5'd13);
    tick();
    chk("rr_idle", bus.cdb_valid, 2'b00);

    // Single result from FU2 (rr_ptr back at 0).
    set_fu(2, 7'd12, 32'hDEADBEEF, 5'd3);
    tick();
    chk("single_e", bus.cdb_valid, 2'b00);
    bus.fu_valid = '0;
    tick();
    chk("single_e1_valid", bus.cdb_valid, 2'b01);
    lane("single_l0", 0, 7'd12, 32'hDEADBEEF, 5'd3);
    tick();
    chk("single_e2_valid", bus.cdb_valid, 2'b00);

    // Stall: rr_ptr=3, FU0..FU2 loaded; FU0/FU1 go out, then 3 stalled cycles.
    set_fu(0, 7'd30, 32'h300, 5'd30);
    set_fu(1, 7'd31, 32'h310, 5'd31);
    set_fu(2, 7'd32, 32'h320, 5'd1);
    tick();
    bus.fu_valid = '0;
    tick();
    chk("stall_first_valid", bus.cdb_valid, 2'b11);
    lane("stall_first_l0", 0, 7'd30, 32'h300, 5'd30);
    lane("stall_first_l1", 1, 7'd31, 32'h310, 5'd31);
    bus.cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_hold_valid", bus.cdb_valid, 2'b11);
      lane("stall_hold_l0", 0, 7'd30, 32'h300, 5'd30);
      lane("stall_hold_l1", 1, 7'd31, 32'h310, 5'd31);
    end
    bus.cdb_ready = 1'b1;
    tick();
    chk("stall_resume_valid", bus.cdb_valid, 2'b01);
    lane("stall_resume_l0", 0, 7'd32, 32'h320, 5'd1);
    chk("stall_l1_data_hold", bus.cdb_register_addr[1], 7'd31);
    tick();
    chk("stall_no_dup", bus.cdb_valid, 2'b00);

    // Backpressure: bus stalled holding FU0's result while FU1 fills its FIFO.
    bus.cdb_ready = 1'b0;
    set_fu(0, 7'd40, 32'h400, 5'd4);
    tick();
    bus.fu_valid = '0;
    set_fu(1, 7'd41, 32'h411, 5'd5);
    tick();
    chk("bp_fu0_valid", bus.cdb_valid, 2'b01);
    chk("bp_fu0_addr", bus.cdb_register_addr[0], 7'd40);
    set_fu(1, 7'd42, 32'h422, 5'd6);
    tick();
    chk("bp_full_ready", bus.fu_ready, 4'b1101);
    chk("bp_stall_addr", bus.cdb_register_addr[0], 7'd40);
    set_fu(1, 7'd43, 32'h433, 5'd7);
    tick();
    chk("bp_still_full", bus.fu_ready[1], 1'b0);
    chk("bp_stall_valid", bus.cdb_valid, 2'b01);
    chk("bp_stall_addr2", bus.cdb_register_addr[0], 7'd40);
    bus.cdb_ready = 1'b1;
    tick();
    chk("bp_r1_valid", bus.cdb_valid, 2'b01);
    lane("bp_r1", 0, 7'd41, 32'h411, 5'd5);
    chk("bp_ready_again", bus.fu_ready[1], 1'b1);
    tick();
    lane("bp_r2", 0, 7'd42, 32'h422, 5'd6);
    bus.fu_valid = '0;
    tick();
    lane("bp_r3", 0, 7'd43, 32'h433, 5'd7);
    chk("bp_r3_valid", bus.cdb_valid, 2'b01);
    tick();
    chk("bp_drained", bus.cdb_valid, 2'b00);

    // Same-cycle push/pop on FU0.
    set_fu(0, 7'd50, 32'h500, 5'd8);
    tick();
    set_fu(0, 7'd51, 32'h511, 5'd9);
    tick();
    chk("pp_first_valid", bus.cdb_valid, 2'b01);
    lane("pp_first", 0, 7'd50, 32'h500, 5'd8);
    chk("pp_ready", bus.fu_ready[0], 1'b1);
    bus.fu_valid = '0;
    tick();
    chk("pp_second_valid", bus.cdb_valid, 2'b01);
    lane("pp_second", 0, 7'd51, 32'h511, 5'd9);
    tick();
    chk("pp_idle", bus.cdb_valid, 2'b00);

    // Reset mid-stream: lanes valid and stalled, three results buffered.
    set_fu(1, 7'd61, 32'h610, 5'd11);
    set_fu(2, 7'd62, 32'h620, 5'd12);
    set_fu(3, 7'd63, 32'h630, 5'd13);
    tick();
    bus.fu_valid = '0;
    tick();
    chk("mid_valid", bus.cdb_valid, 2'b11);
    bus.cdb_ready = 1'b0;
    set_fu(0, 7'd60, 32'h600, 5'd10);
    set_fu(1, 7'd64, 32'h640, 5'd14);
    tick();
    bus.fu_valid = '0;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.cdb_valid, 2'b00);
    chk("mid_rst_ready", bus.fu_ready, 4'b0000);
    chk("mid_rst_addr", bus.cdb_register_addr, 14'd0);
    tick();
    reset = 1'b1;
    bus.cdb_ready = 1'b1;
    #1;
    chk("mid_rel_ready", bus.fu_ready, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_stale", bus.cdb_valid, 2'b00);
    end

    // rr_ptr restarted at 0: FU1 takes lane0, FU3 lane1.
    set_fu(3, 7'd73, 32'h730, 5'd23);
    set_fu(1, 7'd71, 32'h710, 5'd21);
    tick();
    bus.fu_valid = '0;
    tick();
    chk("rr0_valid", bus.cdb_valid, 2'b11);
    lane("rr0_l0", 0, 7'd71, 32'h710, 5'd21);
    lane("rr0_l1", 1, 7'd73, 32'h730, 5'd23);
    tick();
    chk("rr0_idle", bus.cdb_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer (master) side of the Common Data Bus; the reservation stations and register status table consume it.
- Accepts completed results from NUM_FU functional units through per-FU valid/ready handshakes.
- Buffers each FU's results in a small per-FU FIFO.
- Each cycle, grants up to NUM_CDB FIFO heads in round-robin order and broadcasts them as registered CDB lanes. Lanes carry valid, physical destination register, value and ROB tag.

Parameters:
- NUM_FU, 4: number of functional-unit result sources.
- NUM_CDB, 2: number of CDB broadcast lanes; 1 <= NUM_CDB <= NUM_FU.
- FIFO_DEPTH, 2: entries per FU FIFO; power of two, >= 1.
- REG_VAL_WIDTH, 32: result value width.
- PHYS_REG_WIDTH, 7: physical register address width.
- ROB_TAG_WIDTH, 5: ROB tag width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fu_valid  in  NUM_FU  result valid, one bit per FU.
- fu_ready  out  NUM_FU  FIFO can accept, one bit per FU.
- fu_dst_reg_addr  in  NUM_FU*PHYS_REG_WIDTH  destination physical register per FU.
- fu_result_val  in  NUM_FU*REG_VAL_WIDTH  result value per FU.
- fu_inst_tag  in  NUM_FU*ROB_TAG_WIDTH  ROB tag per FU.
- cdb_ready  in  1  all CDB consumers can accept this cycle.
- cdb_valid  out  NUM_CDB  lane valid.
- cdb_register_addr  out  NUM_CDB*PHYS_REG_WIDTH  lane destination register.
- cdb_register_val  out  NUM_CDB*REG_VAL_WIDTH  lane value.
- cdb_inst_tag  out  NUM_CDB*ROB_TAG_WIDTH  lane ROB tag.

Behaviour:
- Reset (reset==0, asynchronous):
  - All FIFOs empty (count=0, pointers=0); rr_ptr=0.
  - cdb_valid=0; cdb_register_addr, cdb_register_val and cdb_inst_tag = 0.
  - fu_ready=all ones once reset is released; fu_ready=0 while reset is asserted.
  - Reset mid-operation discards all buffered and in-flight results.
- Enqueue:
  - fu_ready[i] = (count[i] < FIFO_DEPTH), combinational from count only. No full-with-simultaneous-dequeue bypass.
  - Transfer occurs when fu_valid[i] && fu_ready[i] at the rising edge; {addr,val,tag} is written at wr_ptr[i].
  - Pointers wrap modulo FIFO_DEPTH.
- Advance condition: adv = cdb_ready || ~|cdb_valid. When adv=0, every CDB output register, FIFO head and rr_ptr holds its value.
- Arbitration (combinational, evaluated every cycle):
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - The first NUM_CDB FUs with non-empty FIFOs are granted. The k-th grant in scan order drives lane k.
  - A FU is granted at most once per cycle.
  - Only FIFO contents are eligible; a result arriving in the same cycle is not.
- Broadcast (registered, on the edge where adv=1):
  - Lane k loads the granted head and cdb_valid[k]<=1. Ungranted lanes get cdb_valid[k]<=0; their data fields hold.
  - Each granted FIFO pops 1 entry.
  - rr_ptr <= (last granted index + 1) mod NUM_FU. With no grants, rr_ptr is unchanged.
- Latency:
  - A result accepted at edge E into an empty, uncontended FIFO appears on the CDB after edge E+1 and stays for 1 cycle when cdb_ready=1.
  - Each result is broadcast exactly once, in per-FU FIFO order.
- Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
- Full FIFO: fu_ready drops the cycle after the fill. The FU must hold fu_valid and its data until fu_ready=1.
- cdb_ready is sampled only at edges. Outputs remain stable while stalled.
- Counts never exceed FIFO_DEPTH and never underflow. An assertion is required on any push when full or pop when empty.

Test Plan:
- Reset: drive reset=0 mid-stream with 3 results buffered -> cdb_valid=0 and fu_ready=4'b0000 immediately. After release, fu_ready=4'b1111 and no stale result is ever broadcast.
- Single result: FU2 pushes {addr=7'd12, val=32'hDEADBEEF, tag=5'd3} at edge E, cdb_ready=1 -> after E+1, cdb_valid=2'b01, lane0 = {12, DEADBEEF, 3}. After E+2, cdb_valid=0.
- Contention round robin: all 4 FUs push simultaneously, rr_ptr=0, NUM_CDB=2 -> first broadcast is FU0 on lane0 and FU1 on lane1. Next broadcast is FU2/FU3; rr_ptr returns to 0.
- Stall: hold cdb_ready=0 for 3 cycles while lanes are valid -> outputs bit-identical for 3 cycles and no FIFO pops. After cdb_ready=1, the next grants proceed with no loss or duplication.
- Backpressure: cdb_ready=0, FU1 pushes FIFO_DEPTH=2 results -> fu_ready[1]=0. The third result is held by the FU and accepted only after the CDB drains; order 1,2,3 is preserved.
- Same-cycle push/pop: FU0 FIFO holds 1 entry, FU0 pushes while being granted -> count stays 1 and the new value is broadcast on the next advance.
